// File: rtl/int_timer_mc.sv
// int_timer_mc: multi-channel programmable interval timer with sticky
// pending/overrun flags, explicit acknowledge and a free-running counter.
module int_timer_mc #(
  parameter int CHANNELS       = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int PRESCALE_SHIFT = 12,
  parameter int FREE_WIDTH     = 32,
  parameter int SEL_WIDTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [SEL_WIDTH-1:0]  wr_sel,
  input  logic [CNT_WIDTH-1:0]  wr_val,
  input  logic                  wr_periodic,
  input  logic [CHANNELS-1:0]   ack,
  output logic [CHANNELS-1:0]   pending,
  output logic [CHANNELS-1:0]   overrun,
  output logic [CHANNELS-1:0]   active,
  output logic                  do_int,
  output logic [FREE_WIDTH-1:0] free_count
);

  localparam int RW = CNT_WIDTH + PRESCALE_SHIFT;
  localparam logic [SEL_WIDTH:0] CH_LIM = (SEL_WIDTH+1)'(CHANNELS);

  logic [RW-1:0]         reload_q [CHANNELS];
  logic [RW-1:0]         reload_d [CHANNELS];
  logic [RW-1:0]         count_q  [CHANNELS];
  logic [RW-1:0]         count_d  [CHANNELS];
  logic [CHANNELS-1:0]   periodic_q, periodic_d;
  logic [CHANNELS-1:0]   active_q, active_d;
  logic [CHANNELS-1:0]   pending_q, pending_d;
  logic [CHANNELS-1:0]   overrun_q, overrun_d;
  logic [FREE_WIDTH-1:0] free_q;

  logic [RW-1:0]       wr_load;
  logic                sel_ok;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] expire;

  // Interval N becomes N*2^P clocks; the -1 accounts for the expiry cycle.
  assign wr_load = (RW'(wr_val) << PRESCALE_SHIFT) - RW'(1);
  assign sel_ok  = {1'b0, wr_sel} < CH_LIM;

  always_comb begin
    wr_hit = '0;
    expire = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_en && sel_ok && (wr_sel == SEL_WIDTH'(i));
      expire[i] = active_q[i] && (count_q[i] == '0);
    end
  end

  always_comb begin
    reload_d   = reload_q;
    count_d    = count_q;
    periodic_d = periodic_q;
    active_d   = active_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (active_q[i] && count_q[i] != '0)
        count_d[i] = count_q[i] - RW'(1);
      // Expiry beats a same-cycle ack: flag stays set, overrun is cleared.
      if (expire[i]) begin
        pending_d[i] = 1'b1;
        overrun_d[i] = !ack[i] && (overrun_q[i] || pending_q[i]);
        if (periodic_q[i])
          count_d[i] = reload_q[i];
        else
          active_d[i] = 1'b0;
      end else if (ack[i]) begin
        pending_d[i] = 1'b0;
        overrun_d[i] = 1'b0;
      end
      if (wr_hit[i]) begin
        if (wr_val != '0) begin
          reload_d[i]   = wr_load;
          count_d[i]    = wr_load;
          periodic_d[i] = wr_periodic;
          active_d[i]   = 1'b1;
        end else begin
          active_d[i] = 1'b0;
          count_d[i]  = count_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        reload_q[i] <= '0;
        count_q[i]  <= '0;
      end
      periodic_q <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      free_q     <= '0;
    end else begin
      reload_q   <= reload_d;
      count_q    <= count_d;
      periodic_q <= periodic_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      free_q     <= free_q + FREE_WIDTH'(1);
    end
  end

  assign pending    = pending_q;
  assign overrun    = overrun_q;
  assign active     = active_q;
  assign do_int     = |pending_q;
  assign free_count = free_q;

endmodule

// File: tb/tb_int_timer_mc.sv
// tb_int_timer_mc: directed scenarios plus random traffic checked against
// a deadline-based reference model of the timer.
module tb_int_timer_mc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_sel = '0;
  logic [5:0] wr_val = '0;
  logic       wr_periodic = 1'b0;
  logic [3:0] ack = '0;
  logic [3:0] pending, overrun, active;
  logic       do_int;
  logic [7:0] free_count;

  int checks = 0;
  int failures = 0;

  int_timer_mc #(
    .CHANNELS(4), .CNT_WIDTH(6), .PRESCALE_SHIFT(2),
    .FREE_WIDTH(8), .SEL_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_val(wr_val), .wr_periodic(wr_periodic), .ack(ack),
    .pending(pending), .overrun(overrun), .active(active),
    .do_int(do_int), .free_count(free_count)
  );

  always #5 clk = ~clk;

  // Reference model: absolute edge deadlines instead of countdowns.
  int m_t = 0;
  int m_free = 0;
  bit m_act[4], m_per[4], m_pend[4], m_ovr[4];
  int m_next[4], m_len[4];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit we, input int s,
                            input int v, input bit p, input logic [3:0] a);
    bit ex;
    m_t++;
    if (r) begin
      m_free = 0;
      for (int i = 0; i < 4; i++) begin
        m_act[i] = 0; m_per[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
        m_len[i] = 0; m_next[i] = 0;
      end
      return;
    end
    m_free = (m_free + 1) % 256;
    for (int i = 0; i < 4; i++) begin
      ex = m_act[i] && (m_next[i] == m_t);
      if (ex) begin
        m_ovr[i] = a[i] ? 1'b0 : (m_ovr[i] | m_pend[i]);
        m_pend[i] = 1;
        if (m_per[i]) m_next[i] = m_t + m_len[i];
        else m_act[i] = 0;
      end else if (a[i]) begin
        m_pend[i] = 0;
        m_ovr[i] = 0;
      end
      if (we && s == i) begin
        if (v != 0) begin
          m_len[i] = v * 4;
          m_next[i] = m_t + m_len[i];
          m_per[i] = p;
          m_act[i] = 1;
        end else begin
          m_act[i] = 0;
        end
      end
    end
  endtask

  task automatic tick(input bit r, input bit we, input logic [2:0] s,
                      input logic [5:0] v, input bit p,
                      input logic [3:0] a);
    logic [3:0] ep, eo, ea;
    rst = r; wr_en = we; wr_sel = s; wr_val = v;
    wr_periodic = p; ack = a;
    @(posedge clk);
    model_step(r, we, int'(s), int'(v), p, a);
    #1;
    for (int i = 0; i < 4; i++) begin
      ep[i] = m_pend[i]; eo[i] = m_ovr[i]; ea[i] = m_act[i];
    end
    check("pending", pending, ep);
    check("overrun", overrun, eo);
    check("active", active, ea);
    check("do_int", do_int, |ep);
    check("free_count", free_count, m_free);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_pend(input int ch, input int limit, output int n);
    n = 0;
    do begin
      tick(0, 0, 0, 0, 0, 0);
      n++;
    end while (!pending[ch] && n < limit);
  endtask

  int n;
  logic [3:0] act_snap;

  initial begin
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 1, 6'd3, 0, 4'hF);
    idle(10);
    check("reset_free10", free_count, 10);
    check("reset_pending", pending, 0);
    check("reset_active", active, 0);
    check("reset_do_int", do_int, 0);

    // one-shot ch1, 3 units
    tick(0, 1, 1, 6'd3, 0, 0);
    wait_pend(1, 100, n);
    check("oneshot_latency", n, 12);
    check("oneshot_do_int", do_int, 1);
    check("oneshot_inactive", active[1], 0);
    idle(50);
    tick(0, 0, 0, 0, 0, 4'b0010);
    check("oneshot_acked", pending[1], 0);

    // periodic ch0 with ack two cycles after each expiry
    tick(0, 1, 0, 6'd2, 1, 0);
    for (int k = 0; k < 3; k++) begin
      wait_pend(0, 100, n);
      check("periodic_latency", n, (k == 0) ? 8 : 6);
      idle(1);
      tick(0, 0, 0, 0, 0, 4'b0001);
      check("periodic_ack", pending[0], 0);
      check("periodic_no_ovr", overrun[0], 0);
    end
    tick(0, 1, 0, 6'd0, 0, 0);

    // overrun on ch2
    tick(0, 1, 2, 6'd1, 1, 0);
    wait_pend(2, 100, n);
    check("ovr_first_latency", n, 4);
    check("ovr_first_flag", overrun[2], 0);
    idle(4);
    check("ovr_second_flag", overrun[2], 1);
    tick(0, 0, 0, 0, 0, 4'b0100);
    check("ovr_ack_pend", pending[2], 0);
    check("ovr_ack_ovr", overrun[2], 0);
    tick(0, 1, 2, 6'd0, 0, 0);

    // ack on the exact expiry cycle, then a stop mid-count
    tick(0, 1, 3, 6'd2, 0, 0);
    idle(7);
    tick(0, 0, 0, 0, 0, 4'b1000);
    check("ackexp_pend", pending[3], 1);
    check("ackexp_ovr", overrun[3], 0);
    tick(0, 0, 0, 0, 0, 4'b1000);
    tick(0, 1, 3, 6'd5, 1, 0);
    idle(6);
    tick(0, 1, 3, 6'd0, 0, 0);
    check("stop_inactive", active[3], 0);
    idle(40);
    check("stop_no_expiry", pending[3], 0);

    // restart halfway through a countdown
    tick(0, 1, 1, 6'd4, 0, 0);
    idle(8);
    tick(0, 1, 1, 6'd3, 0, 0);
    wait_pend(1, 100, n);
    check("restart_latency", n, 12);
    tick(0, 0, 0, 0, 0, 4'b0010);

    // out-of-range select is ignored
    tick(0, 1, 0, 6'd9, 1, 0);
    act_snap = active;
    tick(0, 1, 3'd5, 6'd7, 1, 0);
    check("badsel_active", active, act_snap);

    // reset mid-count aborts everything
    tick(0, 1, 2, 6'd5, 1, 0);
    idle(5);
    tick(1, 0, 0, 0, 0, 0);
    check("rst_active", active, 0);
    check("rst_free", free_count, 0);
    idle(40);
    check("rst_no_expiry", pending, 0);

    // largest interval
    tick(0, 1, 2, 6'd63, 0, 0);
    wait_pend(2, 400, n);
    check("max_latency", n, 252);
    tick(0, 0, 0, 0, 0, 4'b0100);

    // free counter wrap
    tick(1, 0, 0, 0, 0, 0);
    idle(255);
    check("free_255", free_count, 255);
    idle(1);
    check("free_wrap", free_count, 0);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      tick(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 5) == 0),
           3'($urandom_range(0, 7)),
           6'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           4'($urandom & $urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
